// File: rtl/pin_protocol_pkg.sv
`default_nettype none
// ============================================================================
// pin_protocol_pkg : shared types and constants for the parking-gate PIN link
// Revision: 1.0
// ============================================================================
package pin_protocol_pkg;

  localparam int BCD_W = 4;

  // Factory PIN, also known to the gate controller
  localparam logic [15:0] DEFAULT_CODE = 16'h2468;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    SEND      = 3'd2,
    WAIT_RESP = 3'd3,
    GRANTED   = 3'd4,
    LOCKED    = 3'd5
  } pin_state_t;

endpackage
`default_nettype wire

// File: rtl/pin_digit_buffer.sv
`default_nettype none
// ============================================================================
// pin_digit_buffer : BCD shift register with saturating digit count
// Revision: 1.0
// ============================================================================
module pin_digit_buffer
  import pin_protocol_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      shift_en,
  input  logic [BCD_W-1:0]          digit,
  output logic [BCD_W*DIGITS-1:0]   buffer,
  output logic [2:0]                count,
  output logic                      full
);

  localparam int CODE_W = BCD_W * DIGITS;

  logic [CODE_W-1:0] shifted;

  if (DIGITS == 1) begin : g_single
    assign shifted = digit;
  end else begin : g_multi
    assign shifted = {buffer[CODE_W-BCD_W-1:0], digit};
  end

  assign full = (count == 3'(DIGITS));

  // Shifts are dropped once full so the first digits are never pushed out
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      buffer <= '0;
      count  <= '0;
    end else if (shift_en && !full) begin
      buffer <= shifted;
      count  <= count + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pin_entry_terminal.sv
`default_nettype none
// ============================================================================
// pin_entry_terminal : keypad-side PIN collector and code/code_ack initiator
// Revision: 1.0
// ============================================================================
module pin_entry_terminal
  import pin_protocol_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int ENTRY_TIMEOUT = 255,
  parameter int RESP_TIMEOUT  = 16,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        session_start,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  input  logic        key_enter,
  input  logic        open_gate,
  input  logic        wrong_pin,
  input  logic        blocked_gate,
  output logic [15:0] code,
  output logic        code_ack,
  output logic [2:0]  digit_count,
  output logic        entry_timeout,
  output logic        resp_timeout,
  output logic        locked
);

  localparam int CODE_W = BCD_W * DIGITS;

  pin_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
  logic [15:0]       code_next;
  logic              ack_next, entry_to_next, resp_to_next, locked_next;
  logic              buf_clear, buf_shift, buf_full;
  logic              key_any, digit_ok;
  logic [CODE_W-1:0] buffer;

  pin_digit_buffer #(
    .DIGITS (DIGITS)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .clear    (buf_clear),
    .shift_en (buf_shift),
    .digit    (key_digit),
    .buffer   (buffer),
    .count    (digit_count),
    .full     (buf_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      code          <= '0;
      code_ack      <= 1'b0;
      entry_timeout <= 1'b0;
      resp_timeout  <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      code          <= code_next;
      code_ack      <= ack_next;
      entry_timeout <= entry_to_next;
      resp_timeout  <= resp_to_next;
      locked        <= locked_next;
    end
  end

  // A timeout fires on the cycle whose increment would reach the limit
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    cnt_inc       = cnt + CNT_W'(1);
    code_next     = code;
    ack_next      = code_ack;
    entry_to_next = 1'b0;
    resp_to_next  = 1'b0;
    locked_next   = 1'b0;
    buf_clear     = 1'b0;
    buf_shift     = 1'b0;
    key_any       = key_valid | key_clear | key_enter;
    digit_ok      = key_valid && (key_digit <= 4'd9);

    case (state)
      IDLE: begin
        if (session_start) begin
          state_next = COLLECT;
          buf_clear  = 1'b1;
          cnt_next   = '0;
        end
      end
      COLLECT: begin
        if (key_any) begin
          cnt_next = '0;
          if (key_clear) begin
            buf_clear = 1'b1;
          end else if (key_enter) begin
            if (buf_full) state_next = SEND;
          end else if (digit_ok) begin
            buf_shift = 1'b1;
          end
        end else if (cnt_inc == CNT_W'(ENTRY_TIMEOUT)) begin
          entry_to_next = 1'b1;
          buf_clear     = 1'b1;
          cnt_next      = '0;
          state_next    = IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      SEND: begin
        code_next  = 16'(buffer);
        ack_next   = 1'b1;
        cnt_next   = '0;
        state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (blocked_gate) begin
          ack_next    = 1'b0;
          locked_next = 1'b1;
          state_next  = LOCKED;
        end else if (open_gate) begin
          ack_next   = 1'b0;
          state_next = GRANTED;
        end else if (wrong_pin) begin
          ack_next   = 1'b0;
          buf_clear  = 1'b1;
          cnt_next   = '0;
          state_next = COLLECT;
        end else if (cnt_inc == CNT_W'(RESP_TIMEOUT)) begin
          resp_to_next = 1'b1;
          ack_next     = 1'b0;
          buf_clear    = 1'b1;
          cnt_next     = '0;
          state_next   = COLLECT;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      GRANTED: begin
        if (!open_gate) begin
          code_next  = '0;
          state_next = IDLE;
        end
      end
      LOCKED: begin
        locked_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/pin_entry_terminal.md
Name: pin_entry_terminal

Overview:
Keypad-side transmitter for the parking gate PIN protocol. It collects decimal digits from the keypad scanner and packs them into a 16-bit BCD code. It presents the code to the gate controller with a level code_ack handshake, then reacts to the controller's open/wrong/blocked responses. It sits between the keypad scanner and the gate controller, on the initiator end of the code/code_ack interface.

Parameters:
DIGITS, 4, digits per PIN; code width = 4*DIGITS; allowed range 1..4.
ENTRY_TIMEOUT, 255, idle cycles in COLLECT before the session is abandoned.
RESP_TIMEOUT, 16, cycles code_ack stays high without a controller response.
CNT_W, 8, width of the shared timeout counter; must satisfy 2^CNT_W > max(ENTRY_TIMEOUT, RESP_TIMEOUT).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
session_start  in  1  vehicle present at gate (level); sampled only in IDLE
key_valid  in  1  one-cycle strobe: key_digit is valid
key_digit  in  4  keyed value; 0..9 are digits, 10..15 are ignored
key_clear  in  1  one-cycle strobe: erase the buffer
key_enter  in  1  one-cycle strobe: submit the code
open_gate  in  1  controller: PIN accepted
wrong_pin  in  1  controller: PIN rejected
blocked_gate  in  1  controller: attempts exhausted
code  out  16  packed BCD; first digit entered in the most significant nibble
code_ack  out  1  code valid; level held until response or timeout
digit_count  out  3  digits currently buffered, 0..DIGITS
entry_timeout  out  1  one-cycle pulse when an entry session is abandoned
resp_timeout  out  1  one-cycle pulse when the controller gives no response
locked  out  1  high in LOCKED state

Behaviour:
- Reset: state=IDLE; code=0, code_ack=0, digit_count=0, entry_timeout=0, resp_timeout=0, locked=0; timeout counter=0. All outputs are registered.
- IDLE: if session_start=1, go to COLLECT next cycle and clear the buffer, count and counter.
- COLLECT, events with priority key_clear > key_enter > key_valid:
  - key_clear: buffer=0, count=0.
  - key_enter with count==DIGITS: go to SEND.
  - key_enter with count<DIGITS: ignored.
  - key_valid with digit<=9 and count<DIGITS: buffer={buffer[11:0],digit} (shift left 4); count+1.
  - key_valid at count==DIGITS, or with digit>9: ignored.
- COLLECT timeout: the counter increments every cycle and clears on any accepted or ignored key strobe. When the counter reaches ENTRY_TIMEOUT, pulse entry_timeout, clear the buffer and return to IDLE.
- SEND: code<=buffer, code_ack<=1, counter cleared, go to WAIT_RESP. Both outputs become visible on the cycle after entry to SEND.
- WAIT_RESP: code and code_ack are held stable. Responses are sampled each cycle with priority blocked_gate > open_gate > wrong_pin.
  - blocked_gate: code_ack<=0, go to LOCKED.
  - open_gate: code_ack<=0, go to GRANTED.
  - wrong_pin: code_ack<=0, clear buffer and count, go to COLLECT (re-entry allowed).
  - No response: when the counter reaches RESP_TIMEOUT, pulse resp_timeout, code_ack<=0, clear buffer, go to COLLECT.
- code_ack low time: code_ack is guaranteed low for at least one cycle between submissions. The controller counts failed attempts on the falling edge of code_ack. Keystrokes are accepted in COLLECT immediately after the drop, but the next SEND needs a full re-entry, so the rule holds.
- GRANTED: wait for open_gate=0, then go to IDLE and clear code to 0.
- LOCKED: locked=1; all inputs ignored; left only via rst.
- Simultaneous events:
  - session_start held high after GRANTED→IDLE starts a new session on the next cycle.
  - A key strobe in the same cycle as the ENTRY_TIMEOUT expiry: the key wins, and the counter clears.
  - rst mid-handshake drops code_ack on the next edge.
- code is unchanged outside SEND except when cleared after GRANTED. Consumers must qualify it with code_ack.

Decomposition:
- Package pin_protocol_pkg holds:
  - state encoding (IDLE, COLLECT, SEND, WAIT_RESP, GRANTED, LOCKED)
  - BCD digit width (4)
  - the default correct-code constant 16'h2468, shared with the controller and benches
- Sub-module: pin_digit_buffer, the shift register plus saturating count with clear/shift/enable ports. The FSM and timeout counter stay in the top module.

Test Plan:
- Correct PIN: session_start, keys 2,4,6,8, enter; open_gate 3 cycles later → code=16'h2468, code_ack high until open_gate, then low; GRANTED→IDLE after open_gate falls.
- Wrong PIN retry: keys 1,1,1,1, enter, wrong_pin → code_ack drops, digit_count=0, state COLLECT. Then enter 2,4,6,8 → new code_ack rise with code=16'h2468 after at least one cycle low.
- Edits: keys 9,9, key_clear, then 2,4,6,8,7 (5th ignored), a 0xB key (ignored), enter → code=16'h2468.
- Early enter: 3 digits, then enter → no code_ack. The 4th digit plus enter → code_ack.
- Timeouts: no keys for 255 cycles → entry_timeout pulse, IDLE. Submit with no response for 16 cycles → resp_timeout pulse, code_ack=0.
- Lock and reset: blocked_gate during WAIT_RESP alongside open_gate → LOCKED (blocked wins), locked=1, keys ignored. rst → all outputs 0.
